// File: rtl/unrank_ctrl.sv
// unrank_ctrl: sequencer for the unrank threshold table.
// Takes a rank and walks rows 0..ROWS-1. For each row it drives the running
// remainder onto the row comparators and turns the returned gt vector into a
// digit. It then reads back the selected cell value, subtracts it from the
// remainder, and streams the digit out under a valid/ready handshake.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      rank handshake, in_rank = rank to unrank
//   tbl_row/tbl_num        row select and remainder driven to the table
//   tbl_gt                 per-cell (cell > tbl_num) from the table
//   tbl_col/tbl_val        column select and cell value readback
//   dig_valid/dig_ready    digit handshake, dig_data = digit, dig_last = final row
//   done                   one-cycle pulse in the first IDLE cycle after the last digit
//   err                    sticky table-consistency flag
//
// Build option: define UNRANK_CTRL_CHECK_EN to enable the table consistency
// checks that drive err. Without it err is tied to 0.
//
// state | meaning
// IDLE  | waiting for a rank, in_ready high
// CMP   | row comparators evaluate the remainder, digit captured
// SUB   | selected cell value read back and subtracted (saturating)
// OUT   | digit offered to the consumer
module unrank_ctrl #(
  parameter int NUM_WIDTH  = 10,
  parameter int CELL_WIDTH = 10,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_WIDTH-1:0]  in_rank,
  output logic [RW-1:0]         tbl_row,
  output logic [NUM_WIDTH-1:0]  tbl_num,
  input  logic [COLS-1:0]       tbl_gt,
  output logic [CW-1:0]         tbl_col,
  input  logic [CELL_WIDTH-1:0] tbl_val,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [CW-1:0]         dig_data,
  output logic                  dig_last,
  output logic                  done,
  output logic                  err
);

  localparam int MW = (NUM_WIDTH > CELL_WIDTH) ? NUM_WIDTH : CELL_WIDTH;
  localparam int ZW = $clog2(COLS + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CMP, SUB, OUT} state_t;

  state_t               state, state_nx;
  logic [NUM_WIDTH-1:0] rem;
  logic [RW-1:0]        row;
  logic [CW-1:0]        digit;
  logic                 done_q;
  logic                 last;
  logic [ZW-1:0]        zcnt;
  logic [CW-1:0]        digit_cmp;
  logic [MW-1:0]        rem_x, val_x, diff_x;
  logic                 sub_under;
  logic [NUM_WIDTH-1:0] rem_sub;

  assign last = (row == LAST_ROW);

  // Cells at or below the remainder report gt=0; with cumulative thresholds
  // the zero count minus one is the largest column that still fits.
  always_comb begin
    zcnt = '0;
    for (int c = 0; c < COLS; c++)
      if (!tbl_gt[c]) zcnt = zcnt + ZW'(1);
    digit_cmp = (zcnt == '0) ? '0 : CW'(zcnt - ZW'(1));
  end

  // Subtract in the wider of the two widths so neither operand is truncated
  // before the compare; an oversized cell saturates the remainder at zero.
  always_comb begin
    rem_x     = MW'(rem);
    val_x     = MW'(tbl_val);
    diff_x    = rem_x - val_x;
    sub_under = (val_x > rem_x);
    rem_sub   = sub_under ? '0 : NUM_WIDTH'(diff_x);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    tbl_row   = '0;
    tbl_num   = '0;
    tbl_col   = '0;
    dig_valid = 1'b0;
    dig_data  = '0;
    dig_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CMP;
      end
      CMP: begin
        tbl_row  = row;
        tbl_num  = rem;
        state_nx = SUB;
      end
      SUB: begin
        tbl_row  = row;
        tbl_num  = rem;
        tbl_col  = digit;
        state_nx = OUT;
      end
      OUT: begin
        dig_valid = 1'b1;
        dig_data  = digit;
        dig_last  = last;
        if (dig_ready) state_nx = last ? IDLE : CMP;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      row    <= '0;
      digit  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == OUT) && dig_ready && last;
      case (state)
        IDLE: if (in_valid) begin
          rem <= in_rank;
          row <= '0;
        end
        CMP: digit <= digit_cmp;
        SUB: rem <= rem_sub;
        OUT: if (dig_ready && !last) row <= row + RW'(1);
        default: ;
      endcase
    end
  end

  assign done = done_q;

`ifdef UNRANK_CTRL_CHECK_EN
  logic err_q;
  logic thermo_bad;

  // A 1 followed by a 0 in the next-higher column means the row is not monotonic.
  always_comb begin
    thermo_bad = 1'b0;
    for (int c = 0; c < COLS - 1; c++)
      if (tbl_gt[c] && !tbl_gt[c+1]) thermo_bad = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == IDLE && in_valid)
      err_q <= 1'b0;
    else if (state == CMP && (thermo_bad || tbl_gt[0]))
      err_q <= 1'b1;
    else if (state == SUB && (sub_under || (last && rem_sub != '0)))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
